// File: rtl/lcd_pkg.sv
// Shared encodings, colour constants and sync-polarity helpers for the LCD output stage.
`timescale 1ns/1ps
package lcd_pkg;

    typedef enum logic [1:0] {
        TS_PASS  = 2'd0,
        TS_BARS  = 2'd1,
        TS_WHITE = 2'd2,
        TS_CHECK = 2'd3
    } test_sel_e;

    localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;
    localparam logic [23:0] RGB_BLACK = 24'h000000;

    localparam int          COUNT_W   = 10;
    localparam logic [9:0]  COUNT_MAX = 10'd1023;

    function automatic logic asserted(input logic level, input logic active_low);
        return level ^ active_low;
    endfunction

    // Bar order: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        return {{8{~idx[1]}}, {8{~idx[2]}}, {8{~idx[0]}}};
    endfunction

endpackage

// File: rtl/lcd_output_stage_sync_delay_line.sv
// Fixed-depth shift register that delay-matches strobes to the pixel pipeline.
`timescale 1ns/1ps
module sync_delay_line #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             disp_clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout_o = din_i;
        end else begin : g_sr
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge disp_clk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
                end else begin
                    stage_q[0] <= din_i;
                    for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign dout_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/lcd_output_stage.sv
// LCD pin driver: delay-matched syncs, blanking, test patterns, frame counter.
`timescale 1ns/1ps
module lcd_output_stage
    import lcd_pkg::*;
#(
    parameter int          PIPE_LAT        = 2,
    parameter int          BAR_SHIFT       = 7,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1,
    parameter logic [23:0] BLANK_RGB       = 24'h000000
) (
    input  logic       disp_clk,
    input  logic       reset,
    input  logic       en_in,
    input  logic       valid_draw,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [7:0] red_in,
    input  logic [7:0] green_in,
    input  logic [7:0] blue_in,
    input  logic [1:0] test_sel,
    output logic [7:0] disp_red,
    output logic [7:0] disp_green,
    output logic [7:0] disp_blue,
    output logic       disp_hsync,
    output logic       disp_vsync,
    output logic       disp_en,
    output logic [7:0] frame_cnt
);

    localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;

    logic v_d, h_d, s_d;

    sync_delay_line #(
        .WIDTH   (3),
        .DEPTH   (PIPE_LAT),
        .RST_VAL ({1'b0, SYNC_IDLE, SYNC_IDLE})
    ) u_sync_dly (
        .disp_clk (disp_clk),
        .reset    (reset),
        .din_i    ({valid_draw, hsync_in, vsync_in}),
        .dout_o   ({v_d, h_d, s_d})
    );

    logic [COUNT_W-1:0] col_q, col_d;
    logic [COUNT_W-1:0] row_q, row_d;
    test_sel_e          mode_q, mode_d;
    logic [7:0]         frame_q, frame_d;
    logic               s_as_q, v_q;
    logic [23:0]        rgb_q, pix_d;
    logic               hsync_q, vsync_q, en_q;

    logic s_as, vs_start, v_fall;

    assign s_as     = asserted(s_d, SYNC_ACTIVE_LOW);
    assign vs_start = s_as & ~s_as_q;
    assign v_fall   = v_q & ~v_d;

    always_comb begin
        col_d   = '0;
        row_d   = row_q;
        mode_d  = mode_q;
        frame_d = frame_q;

        if (v_d) col_d = (col_q == COUNT_MAX) ? col_q : col_q + 10'd1;

        // A new frame overrides the line increment from a coincident valid fall.
        if (vs_start)                         row_d = '0;
        else if (v_fall && row_q != COUNT_MAX) row_d = row_q + 10'd1;

        if (vs_start) begin
            mode_d  = test_sel_e'(test_sel);
            frame_d = frame_q + 8'd1;
        end
    end

    always_comb begin
        pix_d = BLANK_RGB;
        if (v_d && en_in) begin
            case (mode_q)
                TS_PASS:  pix_d = {red_in, green_in, blue_in};
                TS_BARS:  pix_d = bar_colour(col_q[BAR_SHIFT+2 -: 3]);
                TS_WHITE: pix_d = RGB_WHITE;
                TS_CHECK: pix_d = (col_q[BAR_SHIFT] ^ row_q[BAR_SHIFT]) ? RGB_WHITE : RGB_BLACK;
                default:  pix_d = BLANK_RGB;
            endcase
        end
    end

    always_ff @(posedge disp_clk) begin
        if (reset) begin
            col_q   <= '0;
            row_q   <= '0;
            mode_q  <= TS_PASS;
            frame_q <= '0;
            s_as_q  <= 1'b0;
            v_q     <= 1'b0;
            rgb_q   <= '0;
            hsync_q <= SYNC_IDLE;
            vsync_q <= SYNC_IDLE;
            en_q    <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            mode_q  <= mode_d;
            frame_q <= frame_d;
            s_as_q  <= s_as;
            v_q     <= v_d;
            rgb_q   <= pix_d;
            hsync_q <= h_d;
            vsync_q <= s_d;
            en_q    <= en_in;
        end
    end

    assign {disp_red, disp_green, disp_blue} = rgb_q;
    assign disp_hsync = hsync_q;
    assign disp_vsync = vsync_q;
    assign disp_en    = en_q;
    assign frame_cnt  = frame_q;

endmodule

// File: tb/tb_lcd_output_stage.sv
// Randomized and directed checks of lcd_output_stage against a queue-based reference model.
`timescale 1ns/1ps
module tb_lcd_output_stage;

    localparam int          P     = 2;
    localparam int          BS    = 7;
    localparam bit          AL    = 1'b1;
    localparam logic [23:0] BLANK = 24'h000000;

    logic       disp_clk = 1'b0;
    logic       reset = 1'b1, en_in = 1'b0, valid_draw = 1'b0;
    logic       hsync_in = AL, vsync_in = AL;
    logic [7:0] red_in = '0, green_in = '0, blue_in = '0;
    logic [1:0] test_sel = '0;
    logic [7:0] disp_red, disp_green, disp_blue, frame_cnt;
    logic       disp_hsync, disp_vsync, disp_en;

    always #5 disp_clk = ~disp_clk;

    lcd_output_stage #(
        .PIPE_LAT(P), .BAR_SHIFT(BS), .SYNC_ACTIVE_LOW(AL), .BLANK_RGB(BLANK)
    ) dut (
        .disp_clk(disp_clk), .reset(reset), .en_in(en_in), .valid_draw(valid_draw),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .red_in(red_in), .green_in(green_in),
        .blue_in(blue_in), .test_sel(test_sel), .disp_red(disp_red), .disp_green(disp_green),
        .disp_blue(disp_blue), .disp_hsync(disp_hsync), .disp_vsync(disp_vsync),
        .disp_en(disp_en), .frame_cnt(frame_cnt)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: delay line as a queue, pixel coordinates as plain integers.
    typedef struct packed { logic v; logic h; logic s; } strobe_t;
    strobe_t     dq[$];
    int          m_col, m_row, m_mode, m_frame;
    bit          m_prev_s, m_prev_v;
    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    function automatic int sat(input int x);
        return (x > 1023) ? 1023 : x;
    endfunction

    task automatic step();
        logic [23:0] e_rgb;
        logic        e_h, e_v, e_en;
        strobe_t     cur, del;
        bit          s_as, vs_start;
        @(posedge disp_clk);
        if (reset) begin
            dq.delete();
            for (int i = 0; i < P; i++) dq.push_back('{v:1'b0, h:AL, s:AL});
            m_col = 0; m_row = 0; m_mode = 0; m_frame = 0;
            m_prev_s = 0; m_prev_v = 0;
            e_rgb = '0; e_h = AL; e_v = AL; e_en = 1'b0;
        end else begin
            cur = '{v:valid_draw, h:hsync_in, s:vsync_in};
            dq.push_back(cur);
            del = dq.pop_front();
            s_as = (del.s != AL);
            vs_start = s_as && !m_prev_s;
            e_rgb = BLANK;
            if (del.v && en_in) begin
                case (m_mode)
                    0: e_rgb = {red_in, green_in, blue_in};
                    1: e_rgb = bar_tab[(m_col >> BS) % 8];
                    2: e_rgb = 24'hFFFFFF;
                    default: e_rgb = (((m_col >> BS) + (m_row >> BS)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
                endcase
            end
            e_h = del.h;
            e_v = del.s;
            e_en = en_in;
            if (vs_start) begin
                m_frame = (m_frame + 1) % 256;
                m_mode = test_sel;
                m_row = 0;
            end else if (m_prev_v && !del.v) begin
                m_row = sat(m_row + 1);
            end
            m_col = del.v ? sat(m_col + 1) : 0;
            m_prev_s = s_as;
            m_prev_v = del.v;
        end
        #1;
        chk("rgb", {disp_red, disp_green, disp_blue}, e_rgb);
        chk("hsync", disp_hsync, e_h);
        chk("vsync", disp_vsync, e_v);
        chk("disp_en", disp_en, e_en);
        chk("frame_cnt", frame_cnt, m_frame);
    endtask

    task automatic set_sync(input bit h_as, input bit s_as);
        hsync_in = h_as ^ AL;
        vsync_in = s_as ^ AL;
    endtask

    task automatic vs_pulse(input logic [1:0] tsel);
        test_sel = tsel; valid_draw = 0; en_in = 1;
        set_sync(0, 1); step(); step();
        set_sync(0, 0);
        for (int i = 0; i < P + 2; i++) step();
    endtask

    task automatic frame_run(input int act_w, input int act_l, input int tot_w, input int tot_l,
                             input int sel_at, input logic [1:0] sel_new, input bit rnd);
        int n = 0;
        for (int l = 0; l < tot_l; l++) begin
            for (int x = 0; x < tot_w; x++) begin
                valid_draw = (x < act_w) && (l < act_l);
                set_sync((x >= act_w + 1) && (x < act_w + 3), (l == act_l + 1) || (l == act_l + 2));
                {red_in, green_in, blue_in} = 24'($urandom);
                if (n == sel_at) test_sel = sel_new;
                if (rnd) begin
                    en_in = ($urandom_range(0, 15) != 0);
                    if ($urandom_range(0, 299) == 0) test_sel = 2'($urandom);
                end else begin
                    en_in = 1;
                end
                step();
                n++;
            end
        end
    endtask

    initial begin
        logic [7:0] obs[$];

        // Reset with active inputs
        reset = 1; test_sel = 1; valid_draw = 1; en_in = 1; set_sync(1, 1);
        {red_in, green_in, blue_in} = 24'hA5C3E7;
        repeat (3) step();
        chk("rst_rgb", {disp_red, disp_green, disp_blue}, 24'h0);
        chk("rst_hsync", disp_hsync, 1'b1);
        chk("rst_vsync", disp_vsync, 1'b1);
        chk("rst_en", disp_en, 1'b0);
        chk("rst_frame", frame_cnt, 8'd0);
        reset = 0;
        step(); chk("rel_hsync_1", disp_hsync, 1'b1);
        step(); chk("rel_hsync_2", disp_hsync, 1'b1);
        step(); chk("rel_hsync_3", disp_hsync, 1'b0);
        chk("rel_vsync_3", disp_vsync, 1'b0);
        valid_draw = 0; set_sync(0, 0);
        repeat (4) step();

        // Alignment of delayed valid and RGB
        vs_pulse(0);
        green_in = 0; blue_in = 0;
        for (int c = 0; c < 12; c++) begin
            valid_draw = (c < 4);
            red_in = (c >= 2 && c < 6) ? 8'(8'h10 + c - 2) : 8'h00;
            step();
            if (disp_red != 0) obs.push_back(disp_red);
        end
        chk("align_count", obs.size(), 4);
        for (int i = 0; i < obs.size() && i < 4; i++) chk("align_px", obs[i], 8'h10 + i);

        // Colour bars on an 800-pixel line, then a saturating 1100-pixel line
        vs_pulse(1);
        frame_run(800, 1, 820, 1, -1, 0, 0);
        frame_run(1100, 1, 1110, 1, -1, 0, 0);

        // Mid-frame change 0 -> 2 takes effect only after the next vsync
        vs_pulse(0);
        frame_run(200, 3, 210, 6, 300, 2, 0);
        frame_run(200, 2, 210, 4, -1, 2, 0);

        // Checker needs more than 128 rows
        vs_pulse(3);
        frame_run(140, 132, 144, 134, -1, 3, 0);

        // Random timing, enables and modes
        for (int f = 0; f < 8; f++)
            frame_run($urandom_range(100, 320), $urandom_range(2, 4), 330, 6, -1, 0, 1);

        // Coincident vsync assertion and valid fall: row stays 0
        en_in = 1; set_sync(0, 0);
        for (int c = 0; c < 20; c++) begin
            valid_draw = (c < 5) || (c >= 8 && c < 13);
            set_sync(0, c >= 13 && c < 16);
            step();
        end
        chk("row_coincident", 32'(dut.row_q), 32'd0);
        chk("row_model", 32'(dut.row_q), 32'(m_row));

        // Reset mid-frame with active strobes
        valid_draw = 1; set_sync(1, 1);
        reset = 1; step(); step();
        reset = 0;
        for (int c = 0; c < 8; c++) step();
        valid_draw = 0; set_sync(0, 0);
        repeat (4) step();

        // Frame counter wrap: 257 vsync pulses after reset
        reset = 1; step(); reset = 0;
        for (int k = 0; k < 257; k++) begin
            set_sync(0, 1); step();
            set_sync(0, 0); step();
        end
        repeat (P + 2) step();
        chk("frame_wrap", frame_cnt, 8'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
